// File: rtl/dma_read_axi4_to_stream_pkg.sv
// dma_calc_pkg: AXI encodings, 4 KB boundary and FSM state shared by the read-DMA block
package dma_calc_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_MOD = 4'b0011;
  localparam int BOUNDARY = 4096;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} dma_state_e;
endpackage

// File: rtl/dma_read_axi4_to_stream_if.sv
// dma_read_axi4_to_stream_if: AXI4 read channels (ar*/r*) plus AXI4-Stream (t*); master = DMA, slave = memory/sink
interface dma_read_axi4_to_stream_if #(
  parameter int ID_WIDTH = 6,
  parameter int ADDR_WIDTH = 49,
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH = 8
);
  logic [ID_WIDTH-1:0] arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [3:0] arqos;
  logic aruser;
  logic arvalid;
  logic arready;
  logic [ID_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast;
  logic rvalid;
  logic rready;
  logic [DATA_WIDTH-1:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
    output tdata, tlast, tvalid,
    input arready, rdata, rresp, rvalid, tready
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid, rready,
    input tdata, tlast, tvalid,
    output arready, rid, rdata, rresp, rlast, rvalid, tready
  );
endinterface

// File: rtl/dma_read_axi4_to_stream_fifo.sv
// dma_rd_fifo: first-word-fall-through sync FIFO; ports clk/rst_n, push/din, pop/dout, empty, free (free entries)
module dma_rd_fifo #(
  parameter int W = 128,
  parameter int PW = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic empty,
  output logic [PW:0] free
);
  logic [W-1:0] mem [2**PW];
  logic [PW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= din;
  assign dout = mem[rp[PW-1:0]];
  assign empty = wp == rp;
  assign free = (PW+1)'(2**PW) - (wp - rp);
endmodule

// File: rtl/dma_read_axi4_to_stream.sv
// dma_read_axi4_to_stream: read DMA (s_start/s_addr/s_len -> busy/done/error) fetching INCR bursts over bus.ar/r and streaming beats on bus.t*
module dma_read_axi4_to_stream
  import dma_calc_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 6,
  parameter int AXI_ADDR_WIDTH = 49,
  parameter int AXI_DATA_SIZE = 4,
  parameter int AXI_LEN_WIDTH = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int LEN_WIDTH = 32,
  parameter int ARID = 0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic s_start,
  input  logic [AXI_ADDR_WIDTH-1:0] s_addr,
  input  logic [LEN_WIDTH-1:0] s_len,
  output logic busy,
  output logic done,
  output logic error,
  dma_read_axi4_to_stream_if.master bus
);
  localparam int DW = 8 << AXI_DATA_SIZE;
  localparam int CW = FIFO_PTR_WIDTH + 1;
  dma_state_e state;
  logic [AXI_ADDR_WIDTH-1:0] addr, ar_addr;
  logic [AXI_LEN_WIDTH-1:0] ar_len;
  logic ar_valid;
  logic [LEN_WIDTH-1:0] rem, len_r, beat_cnt, lim, burst;
  logic [CW-1:0] outstanding, free, credit;
  logic [12:0] to_bound;
  logic empty, push, pop, last_pop, issue;
  logic [DW-1:0] dout;
  assign to_bound = (13'(BOUNDARY) - {1'b0, addr[11:0]}) >> AXI_DATA_SIZE;
  assign lim = LEN_WIDTH'(to_bound) < LEN_WIDTH'(MAX_BURST_LEN) ? LEN_WIDTH'(to_bound) : LEN_WIDTH'(MAX_BURST_LEN);
  assign burst = rem < lim ? rem : lim;
  // beats already reserved by an issued AR count against free space so R can never overflow the FIFO
  assign credit = free - outstanding;
  assign issue = state == ISSUE && !ar_valid && LEN_WIDTH'(credit) >= burst;
  assign push = bus.rvalid && bus.rready;
  assign pop = bus.tvalid && bus.tready;
  assign last_pop = pop && beat_cnt == len_r - LEN_WIDTH'(1);
  dma_rd_fifo #(.W(DW), .PW(FIFO_PTR_WIDTH)) u_fifo (
    .clk(aclk), .rst_n(aresetn), .push(push), .din(bus.rdata), .pop(pop), .dout(dout), .empty(empty), .free(free)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      addr <= '0;
      ar_addr <= '0;
      ar_len <= '0;
      ar_valid <= 1'b0;
      rem <= '0;
      len_r <= '0;
      beat_cnt <= '0;
      outstanding <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push && |bus.rresp) error <= 1'b1;
      if (pop) beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      outstanding <= outstanding + (issue ? CW'(burst) : CW'(0)) - CW'(push);
      if (state == IDLE && s_start) begin
        if (s_len != '0) begin
          state <= ISSUE;
          busy <= 1'b1;
          error <= 1'b0;
          addr <= s_addr & ~AXI_ADDR_WIDTH'((1 << AXI_DATA_SIZE) - 1);
          rem <= s_len;
          len_r <= s_len;
          beat_cnt <= '0;
        end else done <= 1'b1;
      end
      if (issue) begin
        ar_valid <= 1'b1;
        ar_addr <= addr;
        ar_len <= AXI_LEN_WIDTH'(burst - LEN_WIDTH'(1));
      end
      if (ar_valid && bus.arready) begin
        ar_valid <= 1'b0;
        addr <= addr + (AXI_ADDR_WIDTH'(burst) << AXI_DATA_SIZE);
        rem <= rem - burst;
        if (rem == burst) state <= DRAIN;
      end
      if (busy && last_pop) begin
        state <= IDLE;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  assign bus.arid = AXI_ID_WIDTH'(ARID);
  assign bus.araddr = ar_addr;
  assign bus.arlen = ar_len;
  assign bus.arsize = 3'(AXI_DATA_SIZE);
  assign bus.arburst = BURST_INCR;
  assign bus.arlock = 1'b0;
  assign bus.arcache = CACHE_MOD;
  assign bus.arprot = 3'b000;
  assign bus.arqos = 4'b0000;
  assign bus.aruser = 1'b0;
  assign bus.arvalid = ar_valid;
  assign bus.rready = busy;
  assign bus.tvalid = !empty;
  assign bus.tdata = dout;
  assign bus.tlast = !empty && beat_cnt == len_r - LEN_WIDTH'(1);
endmodule

// File: tb/tb_dma_read_axi4_to_stream.sv
// tb_dma_read_axi4_to_stream: random-timing AXI4 memory model and stream sink checked against a burst/beat reference
module tb_dma_read_axi4_to_stream;
  logic aclk = 0, aresetn = 0, s_start = 0;
  logic [48:0] s_addr = '0;
  logic [31:0] s_len = '0;
  logic busy, done, error;
  always #5 aclk = ~aclk;
  dma_read_axi4_to_stream_if bus();
  dma_read_axi4_to_stream dut (
    .aclk(aclk), .aresetn(aresetn), .s_start(s_start), .s_addr(s_addr), .s_len(s_len),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );
  int checks = 0, errors = 0;
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] mw(logic [48:0] a);
    return {a[31:0] ^ 32'hdeadbeef, a[47:16], ~a[31:0], a[31:0] * 32'd2654435761};
  endfunction
  typedef struct {logic [48:0] a; int t; bit err;} beat_t;
  typedef struct {logic [48:0] a; logic [7:0] l;} ar_t;
  beat_t rq[$];
  ar_t eb[$];
  logic [48:0] base, err_a, h_addr;
  logic [7:0] h_len;
  int len_g, t_idx, r_cnt, max_occ, done_cnt, ar_cnt, cyc, last_pop_cyc, done_cyc;
  int tr_pct = 100;
  bit err_en, r_taken, ar_hold;
  initial begin
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = 0; bus.rid = '0; bus.rlast = 0; bus.tready = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        rq.delete(); bus.rvalid = 0; bus.arready = 0; r_taken = 0; ar_hold = 0;
        continue;
      end
      if (r_taken) begin bus.rvalid = 0; r_taken = 0; end
      bus.arready = $urandom_range(99) >= 20;
      if (!bus.rvalid && rq.size() > 0 && rq[0].t <= cyc && $urandom_range(99) >= 20) begin
        bus.rvalid = 1;
        bus.rdata = mw(rq[0].a);
        bus.rresp = rq[0].err ? 2'b10 : 2'b00;
      end
      bus.tready = $urandom_range(99) < tr_pct;
      #1;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (ar_hold) check("ar_stable", {bus.arvalid, bus.araddr, bus.arlen}, {1'b1, h_addr, h_len});
      ar_hold = bus.arvalid && !bus.arready;
      h_addr = bus.araddr; h_len = bus.arlen;
      if (bus.arvalid && bus.arready) begin
        ar_cnt++;
        check("ar_const", {bus.arsize, bus.arburst, bus.arcache, bus.arlock, bus.arprot, bus.arqos, bus.aruser, bus.arid},
              {3'd4, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0, 1'b0, 6'd0});
        if (eb.size() == 0) check("ar_extra", 1, 0);
        else begin
          check("ar_addr_len", {bus.araddr, bus.arlen}, {eb[0].a, eb[0].l});
          eb.pop_front();
        end
        for (int i = 0; i <= int'(bus.arlen); i++) begin
          logic [48:0] ba;
          ba = bus.araddr + 49'(16 * i);
          rq.push_back('{ba, cyc + 10, err_en && ba == err_a});
        end
      end
      if (bus.rvalid && bus.rready) begin rq.pop_front(); r_taken = 1; r_cnt++; end
      if (bus.tvalid && bus.tready) begin
        check("tdata", bus.tdata, mw(base + 49'(16 * t_idx)));
        check("tlast", bus.tlast, t_idx == len_g - 1);
        if (t_idx == len_g - 1) last_pop_cyc = cyc;
        t_idx++;
      end
      if (r_cnt - t_idx > max_occ) max_occ = r_cnt - t_idx;
    end
  end
  task automatic run(logic [48:0] a, int len, int pct, bit inj, int inj_beat, int rst_beat);
    logic [48:0] ca;
    int r, b, room, i;
    base = a & ~49'hF; len_g = len; tr_pct = pct; t_idx = 0; r_cnt = 0; max_occ = 0;
    done_cnt = 0; ar_cnt = 0; last_pop_cyc = -10; done_cyc = -20; eb.delete();
    err_en = inj; err_a = base + 49'(16 * inj_beat);
    ca = base; r = len;
    while (r > 0) begin
      room = (4096 - int'(ca[11:0])) / 16;
      b = r < 16 ? r : 16;
      if (room < b) b = room;
      eb.push_back('{ca, 8'(b - 1)});
      ca += 49'(16 * b);
      r -= b;
    end
    @(negedge aclk);
    s_addr = a; s_len = len; s_start = 1;
    @(negedge aclk);
    s_start = 0;
    if (len == 0) begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      @(negedge aclk);
      check("zero_done_pulse", done, 0);
      check("zero_ar", ar_cnt, 0);
      return;
    end
    check("busy", busy, 1);
    check("err_clr", error, 0);
    if (rst_beat >= 0) begin
      for (i = 0; i < 20000 && t_idx < rst_beat; i++) @(negedge aclk);
      if (i == 20000) check("rst_timeout", 0, 1);
      @(posedge aclk);
      #2 aresetn = 0;
      #1 check("rst_outs", {busy, done, error, bus.arvalid, bus.rready, bus.tvalid, bus.tlast}, 0);
      repeat (3) @(negedge aclk);
      aresetn = 1;
      eb.delete();
      return;
    end
    for (i = 0; i < 20000 && done_cnt == 0; i++) @(negedge aclk);
    if (i == 20000) check("done_timeout", 0, 1);
    @(negedge aclk);
    #2;
    check("done_once", done_cnt, 1);
    check("done_timing", done_cyc, last_pop_cyc + 1);
    check("busy_end", busy, 0);
    check("beats", t_idx, len);
    check("bursts_left", eb.size(), 0);
    check("r_left", rq.size(), 0);
    check("error", error, inj);
    check("no_overflow", max_occ <= 64, 1);
  endtask
  initial begin
    repeat (3) @(negedge aclk);
    check("rst_ctl", {busy, done, error, bus.arvalid, bus.rready, bus.tvalid, bus.tlast}, 0);
    check("rst_ar", {bus.araddr, bus.arlen}, 0);
    aresetn = 1;
    run(49'h0, 64, 100, 0, 0, -1);
    run(49'hFC0, 16, 100, 0, 0, -1);
    run(49'h1_2340, 5, 100, 0, 0, -1);
    run(49'h500, 0, 100, 0, 0, -1);
    run({17'h0, $urandom} & ~49'hF, 256, 30, 0, 0, -1);
    run(49'h2000_0F80, 40, 80, 1, 7, -1);
    run(49'h3000, 3, 100, 0, 0, -1);
    run(49'h8000, 64, 100, 0, 0, 20);
    run(49'h9000, 64, 100, 0, 0, -1);
    for (int k = 0; k < 4; k++) run({9'h0, 8'($urandom), $urandom}, $urandom_range(100, 1), $urandom_range(100, 50), 0, 0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
